// File: rtl/glitch_pkg.sv
// Shared types and frame-layout helpers for the multi-pulse glitch sequencer.
package glitch_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ARMED,
        ST_TRST,
        ST_DELAY,
        ST_PULSE,
        ST_DONE
    } state_t;

    localparam int POL_IDX = 0;

    function automatic int frame_len(input int cw, input int num_pulses);
        return 2 * cw * num_pulses + 1;
    endfunction

    // Field f is D_i for f=2i and W_i for f=2i+1; fields are packed MSB-first above POL.
    function automatic int field_lsb(input int cw, input int num_pulses, input int f);
        return frame_len(cw, num_pulses) - (f + 1) * cw;
    endfunction

endpackage

// File: rtl/glitch_sequencer_if.sv
// Host-side control and glitch-driver signals of the sequencer.
interface glitch_sequencer_if;
    logic cfg_en;
    logic cfg_data;
    logic go;
    logic rearm;
    logic armed;
    logic busy;
    logic done;
    logic glitch;
    logic target_reset;

    modport master (
        output cfg_en, cfg_data, go, rearm,
        input  armed, busy, done, glitch, target_reset
    );

    modport slave (
        input  cfg_en, cfg_data, go, rearm,
        output armed, busy, done, glitch, target_reset
    );
endinterface

// File: rtl/glitch_cfg_shifter.sv
// Serial config frame capture: shift register, bit counter and field unpacking.
module glitch_cfg_shifter
    import glitch_pkg::*;
#(
    parameter int NUM_PULSES = 2,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          shift_en,
    input  logic          bit_in,
    output logic          frame_full,
    output logic [CW-1:0] delay_val [NUM_PULSES],
    output logic [CW-1:0] width_val [NUM_PULSES],
    output logic          pol
);

    localparam int L   = frame_len(CW, NUM_PULSES);
    localparam int BCW = $clog2(L + 1);

    logic [L-1:0]   frame;
    logic [BCW-1:0] bit_cnt;

    // Frame contents are deliberately not cleared so the last config survives cfg_en low.
    always_ff @(posedge clk) begin
        if (clear) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
        if (shift_en) begin
            frame <= {frame[L-2:0], bit_in};
        end
    end

    assign frame_full = shift_en && (bit_cnt == BCW'(L - 1));
    assign pol        = frame[POL_IDX];

    for (genvar i = 0; i < NUM_PULSES; i++) begin : g_unpack
        assign delay_val[i] = frame[field_lsb(CW, NUM_PULSES, 2*i)   +: CW];
        assign width_val[i] = frame[field_lsb(CW, NUM_PULSES, 2*i+1) +: CW];
    end

endmodule

// File: rtl/glitch_sequencer.sv
// Multi-pulse fault-injection sequencer: go synchroniser, sequencing FSM and shared
// delay/width down-counter.
//   state | meaning
//   LOAD  | shifting in config frame, outputs idle (glitch=0)
//   ARMED | frame complete, waiting for a synchronised go edge
//   TRST  | target_reset asserted for TRST_CYCLES
//   DELAY | idle gap D[idx] before pulse idx
//   PULSE | glitch active for W[idx]
//   DONE  | sequence finished, waiting for rearm
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int NUM_PULSES  = 2,
    parameter int CW          = 16,
    parameter int TRST_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic               SYSCLK_P,
    input logic               reset,
    glitch_sequencer_if.slave bus
);

    localparam int IDXW = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1;

    state_t              state, state_nxt;
    logic [IDXW-1:0]     idx, idx_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;

    logic                clear;
    logic                frame_full;
    logic [CW-1:0]       delay_val [NUM_PULSES];
    logic [CW-1:0]       width_val [NUM_PULSES];
    logic                pol;

    logic [SYNC_STAGES-1:0] go_sync;
    logic                   go_prev;
    logic                   trig;

    int                  launch_from;
    logic                l_found;
    state_t              l_state;
    logic [IDXW-1:0]     l_idx;
    logic [CW-1:0]       l_cnt;

    assign clear = reset || !bus.cfg_en;

    glitch_cfg_shifter #(
        .NUM_PULSES (NUM_PULSES),
        .CW         (CW)
    ) u_shifter (
        .clk        (SYSCLK_P),
        .clear      (clear),
        .shift_en   (!clear && state == ST_LOAD),
        .bit_in     (bus.cfg_data),
        .frame_full (frame_full),
        .delay_val  (delay_val),
        .width_val  (width_val),
        .pol        (pol)
    );

    always_ff @(posedge SYSCLK_P) begin
        if (reset) begin
            go_sync <= '0;
            go_prev <= 1'b0;
            trig    <= 1'b0;
        end else begin
            go_sync <= {go_sync[SYNC_STAGES-2:0], bus.go};
            go_prev <= go_sync[SYNC_STAGES-1];
            trig    <= go_sync[SYNC_STAGES-1] && !go_prev;
        end
    end

    always_ff @(posedge SYSCLK_P) begin
        if (clear) begin
            state <= ST_LOAD;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next non-empty pulse at or after launch_from; all-zero pulses take no cycles.
    always_comb begin
        launch_from = 0;
        if (state == ST_DELAY || state == ST_PULSE) begin
            launch_from = int'(idx) + 1;
        end
        l_found = 1'b0;
        l_state = ST_DONE;
        l_idx   = idx;
        l_cnt   = '0;
        for (int j = 0; j < NUM_PULSES; j++) begin
            if (!l_found && j >= launch_from) begin
                if (delay_val[j] != '0) begin
                    l_found = 1'b1;
                    l_state = ST_DELAY;
                    l_idx   = IDXW'(j);
                    l_cnt   = delay_val[j] - 1'b1;
                end else if (width_val[j] != '0) begin
                    l_found = 1'b1;
                    l_state = ST_PULSE;
                    l_idx   = IDXW'(j);
                    l_cnt   = width_val[j] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            ST_LOAD: begin
                if (frame_full) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    if (TRST_CYCLES > 0) begin
                        state_nxt = ST_TRST;
                        cnt_nxt   = CW'(TRST_CYCLES - 1);
                    end else begin
                        state_nxt = l_state;
                        idx_nxt   = l_idx;
                        cnt_nxt   = l_cnt;
                    end
                end
            end
            ST_TRST, ST_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = l_state;
                    idx_nxt   = l_idx;
                    cnt_nxt   = l_cnt;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DELAY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (width_val[idx] != '0) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = width_val[idx] - 1'b1;
                end else begin
                    state_nxt = l_state;
                    idx_nxt   = l_idx;
                    cnt_nxt   = l_cnt;
                end
            end
            ST_DONE: begin
                if (bus.rearm) begin
                    state_nxt = ST_ARMED;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    assign bus.armed        = (state == ST_ARMED);
    assign bus.busy         = (state == ST_TRST) || (state == ST_DELAY) || (state == ST_PULSE);
    assign bus.done         = (state == ST_DONE);
    assign bus.target_reset = (state == ST_TRST);
    assign bus.glitch       = (state == ST_LOAD)  ? 1'b0 :
                              (state == ST_PULSE) ? !pol : pol;

endmodule
